// File: rtl/usb_fs_in_ep_buf.sv
`default_nettype none
// ============================================================================
// Module      : usb_fs_in_ep_buf
// Description : Single-packet buffer for a USB full-speed IN endpoint.
//               The application fills the buffer byte by byte and commits
//               the packet. The buffer then requests the IN arbiter and
//               streams the bytes to the protocol engine. An ACK frees the
//               buffer and flips the DATA0/DATA1 toggle. A retry rewinds the
//               read pointer so the same packet is sent again.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               app_in_*            - application byte stream and commit
//               in_ep_req/grant     - IN arbiter handshake
//               in_ep_data          - current packet byte (0 when none)
//               in_data_get         - protocol engine consumed a byte
//               in_ep_data_done     - every byte of the packet has been read
//               in_xfr_ack/retry    - host ACK / resend request
//               in_ep_toggle        - DATA0/DATA1 selector
// Revision    : 1.0 - initial release
// ============================================================================
module usb_fs_in_ep_buf #(
  parameter int MAX_PKT_SIZE = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] app_in_data,
  input  logic       app_in_valid,
  output logic       app_in_ready,
  input  logic       app_in_commit,
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  output logic [7:0] in_ep_data,
  input  logic       in_data_get,
  output logic       in_ep_data_done,
  input  logic       in_xfr_ack,
  input  logic       in_xfr_retry,
  output logic       in_ep_toggle
);

  // Pointers carry one extra bit so that "full" (== MAX_PKT_SIZE) is representable.
  localparam int              PW      = $clog2(MAX_PKT_SIZE) + 1;
  localparam int              AW      = PW - 1;
  localparam logic [PW-1:0]   MAX_CNT = PW'(MAX_PKT_SIZE);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem [MAX_PKT_SIZE];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] pkt_len;
  logic          toggle;

  logic          in_fill;
  logic          active;
  logic          accept;
  logic          commit_fire;
  logic          ack_fire;
  logic          retry_fire;
  logic          rd_avail;
  logic          get_fire;

  assign in_fill     = (state == ST_FILL);
  assign active      = (state == ST_READY) || (state == ST_SEND);
  assign rd_avail    = (rd_ptr < pkt_len);

  assign accept      = app_in_valid && app_in_ready;
  assign commit_fire = in_fill && app_in_commit;
  assign ack_fire    = active && in_xfr_ack;
  // Ack wins over retry; both win over a byte get in the same cycle.
  assign retry_fire  = active && in_xfr_retry && !in_xfr_ack;
  assign get_fire    = active && in_ep_grant && in_data_get && rd_avail
                       && !in_xfr_ack && !in_xfr_retry;

  assign app_in_ready    = in_fill && (wr_ptr < MAX_CNT);
  assign in_ep_req       = active;
  assign in_ep_data_done = active && (rd_ptr == pkt_len);
  assign in_ep_toggle    = toggle;
  // rd_avail guarantees rd_ptr < MAX_PKT_SIZE, so the truncated index is exact.
  assign in_ep_data      = (in_ep_grant && rd_avail) ? mem[rd_ptr[AW-1:0]] : 8'h00;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: begin
        if (app_in_commit) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (in_xfr_ack)        state_nxt = ST_FILL;
        else if (in_xfr_retry) state_nxt = ST_READY;
        else if (in_ep_grant)  state_nxt = ST_SEND;
      end
      ST_SEND: begin
        // Grant dropping does not release the packet; only ack/retry do.
        if (in_xfr_ack)        state_nxt = ST_FILL;
        else if (in_xfr_retry) state_nxt = ST_READY;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers, packet length and toggle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_len <= '0;
      toggle  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;

      if (commit_fire) begin
        // A byte accepted alongside the commit belongs to this packet.
        pkt_len <= wr_ptr + PW'(accept);
        rd_ptr  <= '0;
      end

      if (ack_fire) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        toggle <= ~toggle;
      end else if (retry_fire) begin
        rd_ptr <= '0;
      end else if (get_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Packet storage (contents are don't-care after reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= app_in_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_fs_in_ep_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_fs_in_ep_buf
// Description : Self-checking bench for usb_fs_in_ep_buf. A packet-level
//               model (byte queues plus a read index) predicts every output
//               each cycle; directed sequences add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_fs_in_ep_buf;

  localparam int MAX = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] app_in_data;
  logic       app_in_valid;
  logic       app_in_ready;
  logic       app_in_commit;
  logic       in_ep_req;
  logic       in_ep_grant;
  logic [7:0] in_ep_data;
  logic       in_data_get;
  logic       in_ep_data_done;
  logic       in_xfr_ack;
  logic       in_xfr_retry;
  logic       in_ep_toggle;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  usb_fs_in_ep_buf #(.MAX_PKT_SIZE(MAX)) dut (
    .clk             (clk),
    .reset           (reset),
    .app_in_data     (app_in_data),
    .app_in_valid    (app_in_valid),
    .app_in_ready    (app_in_ready),
    .app_in_commit   (app_in_commit),
    .in_ep_req       (in_ep_req),
    .in_ep_grant     (in_ep_grant),
    .in_ep_data      (in_ep_data),
    .in_data_get     (in_data_get),
    .in_ep_data_done (in_ep_data_done),
    .in_xfr_ack      (in_xfr_ack),
    .in_xfr_retry    (in_xfr_retry),
    .in_ep_toggle    (in_ep_toggle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%02h required=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Packet-level model: bytes being collected, the committed packet, the
  // number of bytes already handed out, and the toggle.
  // --------------------------------------------------------------------------
  bit         m_fill = 1'b1;
  logic [7:0] m_q[$];
  logic [7:0] m_pkt[$];
  int         m_rd = 0;
  bit         m_tog = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_fill = 1'b1;
      m_q.delete();
      m_pkt.delete();
      m_rd   = 0;
      m_tog  = 1'b0;
    end else if (m_fill) begin
      if (app_in_valid && m_q.size() < MAX) m_q.push_back(app_in_data);
      if (app_in_commit) begin
        m_pkt  = m_q;
        m_rd   = 0;
        m_fill = 1'b0;
      end
    end else begin
      if (in_xfr_ack) begin
        m_fill = 1'b1;
        m_tog  = ~m_tog;
        m_q.delete();
        m_rd   = 0;
      end else if (in_xfr_retry) begin
        m_rd = 0;
      end else if (in_data_get && in_ep_grant && m_rd < m_pkt.size()) begin
        m_rd++;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("app_in_ready", {7'd0, app_in_ready}, {7'd0, (m_fill && m_q.size() < MAX)});
      check("in_ep_req", {7'd0, in_ep_req}, {7'd0, !m_fill});
      check("in_ep_data_done", {7'd0, in_ep_data_done},
            {7'd0, (!m_fill && m_rd == m_pkt.size())});
      check("in_ep_toggle", {7'd0, in_ep_toggle}, {7'd0, m_tog});
      // Data is only defined by the packet while one is held, or zero with no grant.
      if (!in_ep_grant)
        check("in_ep_data_idle", in_ep_data, 8'h00);
      else if (!m_fill)
        check("in_ep_data", in_ep_data, (m_rd < m_pkt.size()) ? m_pkt[m_rd] : 8'h00);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_bytes(input int n, input logic [7:0] first, input logic [7:0] inc);
    for (int i = 0; i < n; i++) begin
      app_in_valid = 1'b1;
      app_in_data  = 8'(first + i * inc);
      cyc();
    end
    app_in_valid = 1'b0;
  endtask

  task automatic commit();
    app_in_commit = 1'b1;
    cyc();
    app_in_commit = 1'b0;
  endtask

  task automatic ack();
    in_xfr_ack = 1'b1;
    cyc();
    in_xfr_ack  = 1'b0;
    in_ep_grant = 1'b0;
  endtask

  initial begin
    reset = 1'b1; app_in_data = 8'h00; app_in_valid = 1'b0; app_in_commit = 1'b0;
    in_ep_grant = 1'b0; in_data_get = 1'b0; in_xfr_ack = 1'b0; in_xfr_retry = 1'b0;
    cyc(); cyc();
    reset  = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_ready", {7'd0, app_in_ready}, 8'h01);
    check("rst_req", {7'd0, in_ep_req}, 8'h00);
    check("rst_data", in_ep_data, 8'h00);
    check("rst_done", {7'd0, in_ep_data_done}, 8'h00);
    check("rst_toggle", {7'd0, in_ep_toggle}, 8'h00);

    // Three-byte packet, read out in full.
    write_bytes(3, 8'h11, 8'h11);
    commit();
    #1;
    check("p1_req", {7'd0, in_ep_req}, 8'h01);
    check("p1_done_early", {7'd0, in_ep_data_done}, 8'h00);
    in_ep_grant = 1'b1;
    #1 check("p1_b0", in_ep_data, 8'h11);
    in_data_get = 1'b1;
    cyc(); #1 check("p1_b1", in_ep_data, 8'h22);
    cyc(); #1 check("p1_b2", in_ep_data, 8'h33);
    cyc(); in_data_get = 1'b0;
    #1;
    check("p1_done", {7'd0, in_ep_data_done}, 8'h01);
    check("p1_data_end", in_ep_data, 8'h00);

    // Ack, then a stray ack while filling.
    ack();
    #1;
    check("ack_ready", {7'd0, app_in_ready}, 8'h01);
    check("ack_req", {7'd0, in_ep_req}, 8'h00);
    check("ack_toggle", {7'd0, in_ep_toggle}, 8'h01);
    ack();
    #1 check("ack2_toggle", {7'd0, in_ep_toggle}, 8'h01);

    // Partial read, retry (with a colliding get), full resend.
    write_bytes(3, 8'hA1, 8'h11);
    commit();
    in_ep_grant = 1'b1;
    in_data_get = 1'b1;
    cyc(); cyc();
    in_data_get = 1'b0;
    #1 check("rt_b2", in_ep_data, 8'hC3);
    in_xfr_retry = 1'b1; in_data_get = 1'b1;
    cyc();
    in_xfr_retry = 1'b0; in_data_get = 1'b0;
    #1;
    check("rt_b0", in_ep_data, 8'hA1);
    check("rt_toggle", {7'd0, in_ep_toggle}, 8'h01);
    in_data_get = 1'b1;
    repeat (3) cyc();
    in_data_get = 1'b0;
    #1 check("rt_done", {7'd0, in_ep_data_done}, 8'h01);
    ack();
    #1 check("rt_ack_toggle", {7'd0, in_ep_toggle}, 8'h00);

    // Full buffer: overflow byte ignored, last byte is the MAX-th written.
    write_bytes(MAX, 8'h05, 8'h03);
    #1 check("full_ready", {7'd0, app_in_ready}, 8'h00);
    app_in_valid = 1'b1; app_in_data = 8'hEE;
    cyc();
    app_in_valid = 1'b0;
    commit();
    in_ep_grant = 1'b1;
    in_data_get = 1'b1;
    repeat (MAX - 1) cyc();
    in_data_get = 1'b0;
    #1;
    check("full_last", in_ep_data, 8'hC2);
    check("full_not_done", {7'd0, in_ep_data_done}, 8'h00);
    in_data_get = 1'b1;
    cyc();
    in_data_get = 1'b0;
    #1 check("full_done", {7'd0, in_ep_data_done}, 8'h01);
    ack();
    #1 check("full_toggle", {7'd0, in_ep_toggle}, 8'h01);

    // Zero-length packet; ack and retry together.
    commit();
    #1;
    check("zlp_req", {7'd0, in_ep_req}, 8'h01);
    check("zlp_done", {7'd0, in_ep_data_done}, 8'h01);
    in_xfr_retry = 1'b1;
    ack();
    in_xfr_retry = 1'b0;
    #1;
    check("zlp_ack_req", {7'd0, in_ep_req}, 8'h00);
    check("zlp_ack_toggle", {7'd0, in_ep_toggle}, 8'h00);

    // Reset in the middle of a send with toggle set.
    write_bytes(1, 8'h5A, 8'h00);
    commit();
    ack();
    #1 check("pre_rst_toggle", {7'd0, in_ep_toggle}, 8'h01);
    write_bytes(2, 8'h10, 8'h01);
    commit();
    in_ep_grant = 1'b1;
    in_data_get = 1'b1;
    cyc();
    in_data_get = 1'b0;
    #1 check("mid_b1", in_ep_data, 8'h11);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("mrst_req", {7'd0, in_ep_req}, 8'h00);
    check("mrst_ready", {7'd0, app_in_ready}, 8'h01);
    check("mrst_toggle", {7'd0, in_ep_toggle}, 8'h00);
    check("mrst_data", in_ep_data, 8'h00);
    in_ep_grant = 1'b0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_fs_in_ep_buf.md
USB_FS_IN_EP_BUF -- requirements
Module: usb_fs_in_ep_buf

Interface
REQ-001 SHALL have parameter MAX_PKT_SIZE, default 64, meaning the buffer depth in bytes; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port app_in_data, input, 8 bits: byte from the application.
REQ-005 SHALL have port app_in_valid, input, 1 bit: app_in_data is valid this cycle.
REQ-006 SHALL have port app_in_ready, output, 1 bit: a byte presented this cycle is accepted.
REQ-007 SHALL have port app_in_commit, input, 1 bit: close the current packet and mark it ready to send.
REQ-008 SHALL have port in_ep_req, output, 1 bit: request to the IN arbiter.
REQ-009 SHALL have port in_ep_grant, input, 1 bit: grant from the IN arbiter.
REQ-010 SHALL have port in_ep_data, output, 8 bits: current packet byte, sent to the arbiter.
REQ-011 SHALL have port in_data_get, input, 1 bit: the protocol engine consumed the current byte.
REQ-012 SHALL have port in_ep_data_done, output, 1 bit: all bytes of the packet have been read.
REQ-013 SHALL have port in_xfr_ack, input, 1 bit: host ACKed the packet.
REQ-014 SHALL have port in_xfr_retry, input, 1 bit: the packet is to be resent (timeout or NAK path).
REQ-015 SHALL have port in_ep_toggle, output, 1 bit: DATA0/DATA1 PID selector for the current packet.

Function
REQ-016 SHALL implement states FILL, READY and SEND, plus an 8-bit x MAX_PKT_SIZE register array, wr_ptr and rd_ptr (each clog2(MAX_PKT_SIZE)+1 bits), and a pkt_len register of the same width.
REQ-017 SHALL assert app_in_ready only when the state is FILL and wr_ptr < MAX_PKT_SIZE.
REQ-018 SHALL, when app_in_valid && app_in_ready, write app_in_data at wr_ptr and increment wr_ptr on the next clock edge.
REQ-019 SHALL ignore app_in_valid when app_in_ready is low: no write and no pointer change.
REQ-020 SHALL, on app_in_commit in FILL, latch pkt_len = wr_ptr (plus 1 if a byte is accepted in the same cycle), set rd_ptr=0 and go to READY.
REQ-021 SHALL ignore app_in_commit outside FILL.
REQ-022 SHALL support a zero-length packet: a commit with wr_ptr=0 and no byte gives pkt_len=0.
REQ-023 SHALL assert in_ep_req combinationally whenever the state is READY or SEND.
REQ-024 SHALL go from READY to SEND on the first cycle in_ep_grant is high.
REQ-025 SHALL drive in_ep_data = mem[rd_ptr] combinationally while in_ep_grant && rd_ptr < pkt_len, and 0 otherwise.
REQ-026 SHALL increment rd_ptr on in_data_get only when in_ep_grant is high, the state is READY or SEND, and rd_ptr < pkt_len; otherwise in_data_get SHALL be ignored.
REQ-027 SHALL assert in_ep_data_done combinationally when the state is READY or SEND and rd_ptr == pkt_len.
REQ-028 SHALL, on in_xfr_ack in READY or SEND, go to FILL, clear wr_ptr and rd_ptr, and invert in_ep_toggle.
REQ-029 SHALL ignore in_xfr_ack in FILL.
REQ-030 SHALL, on in_xfr_retry in READY or SEND without a simultaneous ack, set rd_ptr=0 and go to READY, keeping buffer contents, pkt_len and in_ep_toggle.
REQ-031 SHALL give in_xfr_ack priority over in_xfr_retry when both are high in the same cycle.
REQ-032 SHALL give ack or retry priority over in_data_get in the same cycle.
REQ-033 SHALL keep in_ep_req asserted in SEND even if in_ep_grant drops, so the packet is held until ack or retry.

Reset
REQ-034 SHALL, on reset, set state=FILL, wr_ptr=0, rd_ptr=0, pkt_len=0 and in_ep_toggle=0; memory contents are don't-care.
REQ-035 SHALL, after reset, drive app_in_ready=1, in_ep_req=0, in_ep_data=0 and in_ep_data_done=0.
REQ-036 SHALL let reset override every other input, including mid-SEND, and discard any pending packet.

Verification
REQ-037 Write 0x11, 0x22, 0x33, then commit -> in_ep_req=1 next cycle; with grant and 3 gets, in_ep_data reads 0x11, 0x22, 0x33, then in_ep_data_done=1.
REQ-038 Ack after the above -> state FILL, app_in_ready=1, in_ep_req=0, in_ep_toggle=1; a second ack in FILL -> toggle stays 1.
REQ-039 Read 2 of 3 bytes, then retry -> rd_ptr=0 and in_ep_data=0x11 again with toggle unchanged; full resend followed by ack -> toggle flips once.
REQ-040 Write MAX_PKT_SIZE bytes -> app_in_ready=0; a 65th valid byte is ignored; commit -> pkt_len=64 and the last byte read is the 64th byte written.
REQ-041 Commit with no data -> in_ep_req=1 and in_ep_data_done=1 immediately; ack and retry in the same cycle -> ack wins (FILL, toggle flips).
REQ-042 Reset asserted mid-SEND after 1 get -> next cycle in_ep_req=0, app_in_ready=1, toggle=0, in_ep_data=0.
